stark_cjb_ckpt_alloc: RTL
=========================

Name: stark_cjb_ckpt_alloc

Overview:
Allocates branch checkpoints (rename-map snapshots) to conditional jump/branch instructions flagged by the decode-stage CJB detector, for up to NDEC lanes per cycle. Checkpoints are handed out in program order from a circular pool. They are released in order once resolved, and younger checkpoints are reclaimed on a mispredict. The block sits between decode and rename, and stalls decode when the pool cannot cover a whole decode group.

Parameters:
NCKPT, 16, number of checkpoints; power of two, at least 4.
NDEC, 2, decode lanes per cycle; 1 to 4.
TAGW, $clog2(NCKPT), checkpoint tag width (derived).

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
dec_v  in  NDEC  lane holds a valid decoded instruction
dec_cjb  in  NDEC  lane instruction is a conditional jump/branch
dec_adv  in  1  decode group advances this cycle if not stalled
alloc_v  out  NDEC  checkpoint allocated to lane (combinational)
alloc_tag  out  NDEC*TAGW  allocated tag per lane (combinational)
stall  out  1  decode group must hold (combinational)
res_v  in  1  branch resolution valid
res_tag  in  TAGW  tag of resolved branch
res_misp  in  1  resolved branch mispredicted
free_cnt  out  TAGW+1  free checkpoints (registered)
full  out  1  free_cnt==0 (registered)
err  out  1  sticky: resolve to a non-live tag

Behaviour:
- State: head and tail pointers (TAGW bits, wrap modulo NCKPT); count (TAGW+1 bits); per-entry live[] and done[] bits.
- Reset (rstn==0 at clk edge): head=tail=0, count=0, live=done=0, err=0, free_cnt=NCKPT, full=0. Reset mid-operation discards all checkpoints without exception.
- need = number of lanes with dec_v&dec_cjb. stall = res_v&res_misp | (need > NCKPT-count).
- Allocation is all-or-nothing. If !stall, the k-th requesting lane (in lane order 0 upward) gets alloc_v=1 and alloc_tag=tail+k mod NCKPT. Otherwise alloc_v=0 for all lanes. Lanes without a request have alloc_v=0 and alloc_tag=0.
- Commit on edge when dec_adv & !stall: the allocated entries get live=1 and done=0; tail += need.
- Correct resolve (res_v & !res_misp & live[res_tag]): done[res_tag]=1.
- Mispredict (res_v & res_misp & live[res_tag]):
  - done[res_tag]=1.
  - All entries strictly younger than res_tag (from res_tag+1 up to tail-1) are cleared, live=done=0.
  - tail=res_tag+1.
  - count is reduced by the number cleared.
  - No allocation in the same cycle (stall forces this).
- Resolve to a tag with live==0: ignored, err<=1 (clears only at reset).
- Release: each cycle, if live[head]&done[head], clear that entry, head+1, count-1. At most one release per cycle. Release evaluates pre-edge state, so a resolve of the head entry releases it the following cycle.
- Simultaneous release and mispredict: release of head applies. If res_tag==head, the mispredict clears the entries younger than head, and head then advances past it. The count update accounts for both.
- Simultaneous release and allocate: count_next = count + need - released. Allocation is checked against the pre-edge count, so a slot freed this cycle is not usable until next cycle.
- free_cnt = NCKPT-count and full are registered from next-state.
- Tag arithmetic is modulo NCKPT. "Younger" is measured as distance from head: (tag-head) mod NCKPT.

Test Plan:
- Reset then one lane: dec_v=01, dec_cjb=01, dec_adv=1 -> alloc_v=01, tag0=0; next cycle free_cnt=15, tail=1.
- Two CJBs with a one-slot deficit: fill to count=15, then present dec_cjb=11 -> stall=1, alloc_v=00, count remains 15. Resolve head, release it, re-present -> allocated tags 15 and 0 (wrap), full=1.
- Out-of-order resolve: allocate tags 0,1,2; resolve 2 then 0 -> tag 0 released next cycle; head stops at 1 until tag 1 is resolved, then 1 and 2 release on consecutive cycles; free_cnt back to 16.
- Mispredict: allocate tags 0–5; res_v=1, res_misp=1, res_tag=2 with a dec_cjb request that cycle -> stall=1; tail=3; entries 3–5 cleared; free_cnt=13; next allocation gives tag 3.
- Resolve of a non-live tag 9 on an empty pool -> err=1 sticky, no state change; rstn=0 for one cycle -> err=0, free_cnt=16.
- Reset while 8 checkpoints are live with a mispredict pending -> every output takes its reset value after the edge, and the next allocation gives tag 0.

Source files
------------

// File: rtl/stark_cjb_ckpt_alloc_if.sv
// Decode/resolve interface of the branch checkpoint allocator.
// The master side is decode plus branch resolution; the slave side is the allocator.
interface stark_cjb_ckpt_alloc_if #(
    parameter int NCKPT = 16,
    parameter int NDEC  = 2,
    parameter int TAGW  = $clog2(NCKPT)
);
    logic [NDEC-1:0]      dec_v;
    logic [NDEC-1:0]      dec_cjb;
    logic                 dec_adv;
    logic [NDEC-1:0]      alloc_v;
    logic [NDEC*TAGW-1:0] alloc_tag;
    logic                 stall;
    logic                 res_v;
    logic [TAGW-1:0]      res_tag;
    logic                 res_misp;
    logic [TAGW:0]        free_cnt;
    logic                 full;
    logic                 err;

    modport master (
        output dec_v, dec_cjb, dec_adv, res_v, res_tag, res_misp,
        input  alloc_v, alloc_tag, stall, free_cnt, full, err
    );

    modport slave (
        input  dec_v, dec_cjb, dec_adv, res_v, res_tag, res_misp,
        output alloc_v, alloc_tag, stall, free_cnt, full, err
    );
endinterface

// File: rtl/stark_cjb_ckpt_alloc.sv
// Circular pool of branch checkpoints: in-order allocation to CJB lanes,
// in-order release after resolution, and reclamation of younger entries on mispredict.
module stark_cjb_ckpt_alloc #(
    parameter int NCKPT = 16,
    parameter int NDEC  = 2,
    parameter int TAGW  = $clog2(NCKPT)
) (
    input logic                 clk,
    input logic                 rstn,
    stark_cjb_ckpt_alloc_if.slave bus
);
    localparam logic [TAGW:0] NCKPT_C = (TAGW+1)'(NCKPT);

    logic [TAGW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [TAGW:0]        count_q, count_d, free_q, free_d;
    logic [NCKPT-1:0]     live_q, live_d, done_q, done_d;
    logic                 full_q, full_d, err_q, err_d;

    logic [NDEC-1:0]      req;
    logic [NDEC-1:0]      alloc_v;
    logic [NDEC*TAGW-1:0] alloc_tag;
    logic [TAGW:0]        need, n_clr;
    logic [TAGW-1:0]      k, dist_res, dist_j, slot;
    logic                 stall, misp, res_live, rel, commit;

    assign req      = bus.dec_v & bus.dec_cjb;
    assign misp     = bus.res_v & bus.res_misp;
    assign res_live = live_q[bus.res_tag];
    assign stall    = misp | (need > (NCKPT_C - count_q));
    assign commit   = bus.dec_adv & ~stall;
    assign rel      = live_q[head_q] & done_q[head_q];
    // Age is distance from head, so entries past the resolved tag are the ones to reclaim.
    assign dist_res = bus.res_tag - head_q;
    assign n_clr    = count_q - (TAGW+1)'(1) - {1'b0, dist_res};

    always_comb begin
        need = '0;
        for (int i = 0; i < NDEC; i++) begin
            if (req[i]) need = need + (TAGW+1)'(1);
        end
    end

    always_comb begin
        alloc_v   = '0;
        alloc_tag = '0;
        k         = '0;
        for (int i = 0; i < NDEC; i++) begin
            if (req[i]) begin
                if (!stall) begin
                    alloc_v[i]                  = 1'b1;
                    alloc_tag[i*TAGW +: TAGW]   = tail_q + k;
                end
                k = k + TAGW'(1);
            end
        end
    end

    // Order matters: resolve, then allocate, then release, so a same-cycle release of head wins.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        live_d  = live_q;
        done_d  = done_q;
        err_d   = err_q;
        dist_j  = '0;
        slot    = '0;

        if (bus.res_v) begin
            if (!res_live) begin
                err_d = 1'b1;
            end else begin
                done_d[bus.res_tag] = 1'b1;
                if (bus.res_misp) begin
                    for (int j = 0; j < NCKPT; j++) begin
                        dist_j = TAGW'(j) - head_q;
                        if (live_q[j] && (dist_j > dist_res)) begin
                            live_d[j] = 1'b0;
                            done_d[j] = 1'b0;
                        end
                    end
                    tail_d  = bus.res_tag + TAGW'(1);
                    count_d = count_d - n_clr;
                end
            end
        end

        if (commit) begin
            for (int i = 0; i < NDEC; i++) begin
                if (req[i]) begin
                    slot         = alloc_tag[i*TAGW +: TAGW];
                    live_d[slot] = 1'b1;
                    done_d[slot] = 1'b0;
                end
            end
            tail_d  = tail_q + need[TAGW-1:0];
            count_d = count_d + need;
        end

        if (rel) begin
            live_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + TAGW'(1);
            count_d        = count_d - (TAGW+1)'(1);
        end

        free_d = NCKPT_C - count_d;
        full_d = (count_d == NCKPT_C);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: live/done are pool bookkeeping, not payload storage, so they must reset.
            live_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            free_q  <= NCKPT_C;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
            done_q  <= done_d;
            err_q   <= err_d;
            free_q  <= free_d;
            full_q  <= full_d;
        end
    end

    assign bus.alloc_v   = alloc_v;
    assign bus.alloc_tag = alloc_tag;
    assign bus.stall     = stall;
    assign bus.free_cnt  = free_q;
    assign bus.full      = full_q;
    assign bus.err       = err_q;
endmodule
